// File: rtl/nd_slice_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// nd_slice_scan_sequencer_if
//
// Bundles the command channel, the element (index) stream and the status
// flags of the N-d slice scan sequencer.
//
//   command channel : cmd_valid/cmd_ready plus cmd_order, cmd_base0,
//                     cmd_len0, cmd_rot1, cmd_rot2
//   control         : abort (terminates a running scan)
//   element stream  : idx_valid/idx_ready plus idx0, idx1, idx2, addr,
//                     idx_last
//   status          : busy, done
//
// Modports:
//   slave  - the sequencer itself (accepts commands, produces elements)
//   master - the controller/consumer side that issues commands and
//            accepts elements
// ---------------------------------------------------------------------------
interface nd_slice_scan_sequencer_if #(
  parameter int D0 = 6,
  parameter int D1 = 4,
  parameter int D2 = 3,
  parameter int W0 = $clog2(D0),
  parameter int W1 = $clog2(D1),
  parameter int W2 = $clog2(D2),
  parameter int AW = $clog2(D0 * D1 * D2)
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_order;
  logic [W0-1:0] cmd_base0;
  logic [W0:0]   cmd_len0;
  logic [W1-1:0] cmd_rot1;
  logic [W2-1:0] cmd_rot2;
  logic          abort;

  logic          idx_valid;
  logic          idx_ready;
  logic [W0-1:0] idx0;
  logic [W1-1:0] idx1;
  logic [W2-1:0] idx2;
  logic [AW-1:0] addr;
  logic          idx_last;

  logic          busy;
  logic          done;

  modport slave (
    input  cmd_valid, cmd_order, cmd_base0, cmd_len0, cmd_rot1, cmd_rot2,
    input  abort, idx_ready,
    output cmd_ready, idx_valid, idx0, idx1, idx2, addr, idx_last,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_order, cmd_base0, cmd_len0, cmd_rot1, cmd_rot2,
    output abort, idx_ready,
    input  cmd_ready, idx_valid, idx0, idx1, idx2, addr, idx_last,
    input  busy, done
  );

endinterface

// File: rtl/nd_slice_scan_sequencer.sv
// ---------------------------------------------------------------------------
// nd_slice_scan_sequencer
//
// Index/address sequencer for a packed [D0][D1][D2] array. A command selects
// a contiguous slice of dimension 0 (base0, len0), a loop-nest order and
// rotation offsets on dimensions 1 and 2. The sequencer then emits every
// element of the slice exactly once as an index triple plus flat address,
// one element per idx_valid/idx_ready handshake.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RESET - synchronous, active-high reset
//   bus   - slave side of nd_slice_scan_sequencer_if:
//             cmd_*     command channel, accepted only in IDLE
//             abort     ends a running scan without a done pulse
//             idx_*     registered element stream, addr is the flat address
//             busy      high while not IDLE
//             done      one-cycle pulse after a scan completes (or after an
//                       illegal command is rejected)
//
// Element outputs are registered: the value loaded into the output register
// is always computed from the counters the element will have, so the first
// element appears the cycle after command acceptance and an element only
// changes when it is accepted.
// ---------------------------------------------------------------------------
module nd_slice_scan_sequencer #(
  parameter int D0 = 6,
  parameter int D1 = 4,
  parameter int D2 = 3,
  parameter int W0 = $clog2(D0),
  parameter int W1 = $clog2(D1),
  parameter int W2 = $clog2(D2),
  parameter int AW = $clog2(D0 * D1 * D2)
) (
  input logic                       CLK,
  input logic                       RESET,
  nd_slice_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched command
  logic [2:0]    order_q;
  logic [W0-1:0] base_q;
  logic [W0:0]   len_q;
  logic [W1-1:0] rot1_q;
  logic [W2-1:0] rot2_q;

  // Scan counters for the element currently presented
  logic [W0-1:0] c0;
  logic [W1-1:0] c1;
  logic [W2-1:0] c2;

  // Registered element outputs
  logic          idx_valid_q;
  logic [W0-1:0] idx0_q;
  logic [W1-1:0] idx1_q;
  logic [W2-1:0] idx2_q;
  logic [AW-1:0] addr_q;
  logic          idx_last_q;

  logic cmd_ready;
  logic accept;
  logic cmd_legal;
  logic handshake;
  logic load_en;
  logic finish_run;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // A slice must be non-empty and fit inside dimension 0.
  function automatic logic is_legal(input logic [W0-1:0] base,
                                    input logic [W0:0]   len);
    return (len != '0) && ((int'(base) + int'(len)) <= D0);
  endfunction

  // Nesting position of each dimension, 0 = outermost, 2 = innermost.
  // Packed as {pos2, pos1, pos0}. Orders 6 and 7 fall back to 0-1-2.
  function automatic logic [5:0] nest_pos(input logic [2:0] order);
    case (order)
      3'd1:    return {2'd1, 2'd2, 2'd0};  // 0-2-1
      3'd2:    return {2'd2, 2'd0, 2'd1};  // 1-0-2
      3'd3:    return {2'd1, 2'd0, 2'd2};  // 1-2-0
      3'd4:    return {2'd0, 2'd2, 2'd1};  // 2-0-1
      3'd5:    return {2'd0, 2'd1, 2'd2};  // 2-1-0
      default: return {2'd2, 2'd1, 2'd0};  // 0-1-2
    endcase
  endfunction

  function automatic logic [W1-1:0] rotate1(input logic [W1-1:0] c,
                                            input logic [W1-1:0] rot);
    return W1'((int'(c) + int'(rot)) % D1);
  endfunction

  // rot2 is W2 bits wide and may exceed D2-1, so the modulo is needed even
  // though c2 itself is always in range.
  function automatic logic [W2-1:0] rotate2(input logic [W2-1:0] c,
                                            input logic [W2-1:0] rot);
    return W2'((int'(c) + int'(rot)) % D2);
  endfunction

  // Row-major flat address, evaluated in 32-bit arithmetic before the
  // final truncation to AW bits.
  function automatic logic [AW-1:0] flat_addr(input logic [W0-1:0] i0,
                                              input logic [W1-1:0] i1,
                                              input logic [W2-1:0] i2);
    return AW'((int'(i0) * D1 + int'(i1)) * D2 + int'(i2));
  endfunction

  // ---------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------
  assign accept     = bus.cmd_valid && cmd_ready;
  assign cmd_legal  = is_legal(bus.cmd_base0, bus.cmd_len0);
  assign handshake  = idx_valid_q && bus.idx_ready;

  // ---------------------------------------------------------------------
  // Counter advance: a dimension steps when every dimension nested inside
  // it is at its maximum, and wraps to zero when it is itself at maximum.
  // ---------------------------------------------------------------------
  logic [5:0]    pos;
  logic [1:0]    p0, p1, p2;
  logic          m0, m1, m2;
  logic          step0, step1, step2;
  logic [W0-1:0] c0_adv;
  logic [W1-1:0] c1_adv;
  logic [W2-1:0] c2_adv;

  always_comb begin
    pos = nest_pos(order_q);
    p0  = pos[1:0];
    p1  = pos[3:2];
    p2  = pos[5:4];

    m0 = (int'(c0) == int'(len_q) - 1);
    m1 = (int'(c1) == D1 - 1);
    m2 = (int'(c2) == D2 - 1);

    step0 = ((p1 < p0) || m1) && ((p2 < p0) || m2);
    step1 = ((p0 < p1) || m0) && ((p2 < p1) || m2);
    step2 = ((p0 < p2) || m0) && ((p1 < p2) || m1);

    c0_adv = c0;
    c1_adv = c1;
    c2_adv = c2;
    if (step0) c0_adv = m0 ? '0 : c0 + W0'(1);
    if (step1) c1_adv = m1 ? '0 : c1 + W1'(1);
    if (step2) c2_adv = m2 ? '0 : c2 + W2'(1);
  end

  // ---------------------------------------------------------------------
  // Source of the next element: in IDLE it is the first element of the
  // incoming command, otherwise the advanced counters of the latched one.
  // ---------------------------------------------------------------------
  logic [W0-1:0] s_base;
  logic [W0:0]   s_len;
  logic [W1-1:0] s_rot1;
  logic [W2-1:0] s_rot2;
  logic [W0-1:0] s_c0;
  logic [W1-1:0] s_c1;
  logic [W2-1:0] s_c2;
  logic [W0-1:0] s_idx0;
  logic [W1-1:0] s_idx1;
  logic [W2-1:0] s_idx2;
  logic          s_last;

  always_comb begin
    s_base = base_q;
    s_len  = len_q;
    s_rot1 = rot1_q;
    s_rot2 = rot2_q;
    s_c0   = c0_adv;
    s_c1   = c1_adv;
    s_c2   = c2_adv;
    if (state == IDLE) begin
      s_base = bus.cmd_base0;
      s_len  = bus.cmd_len0;
      s_rot1 = bus.cmd_rot1;
      s_rot2 = bus.cmd_rot2;
      s_c0   = '0;
      s_c1   = '0;
      s_c2   = '0;
    end

    s_idx0 = W0'(int'(s_base) + int'(s_c0));
    s_idx1 = rotate1(s_c1, s_rot1);
    s_idx2 = rotate2(s_c2, s_rot2);
    s_last = (int'(s_c0) == int'(s_len) - 1) &&
             (int'(s_c1) == D1 - 1) &&
             (int'(s_c2) == D2 - 1);
  end

  // Load a new element on a legal command or on a non-final accept in RUN;
  // abort takes priority over a simultaneous accept.
  assign load_en    = ((state == IDLE) && accept && cmd_legal) ||
                      ((state == RUN) && !bus.abort && handshake && !idx_last_q);
  assign finish_run = (state == RUN) &&
                      (bus.abort || (handshake && idx_last_q));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = cmd_legal ? RUN : DONE;
      end
      RUN: begin
        if (bus.abort)                    state_nxt = IDLE;
        else if (handshake && idx_last_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state == IDLE);
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
  end

  assign bus.cmd_ready = cmd_ready;

  // ---------------------------------------------------------------------
  // Command latch, counters and registered element outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      order_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      rot1_q      <= '0;
      rot2_q      <= '0;
      c0          <= '0;
      c1          <= '0;
      c2          <= '0;
      idx_valid_q <= 1'b0;
      idx0_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      addr_q      <= '0;
      idx_last_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && accept) begin
        order_q <= bus.cmd_order;
        base_q  <= bus.cmd_base0;
        len_q   <= bus.cmd_len0;
        rot1_q  <= bus.cmd_rot1;
        rot2_q  <= bus.cmd_rot2;
      end

      if (load_en) begin
        c0          <= s_c0;
        c1          <= s_c1;
        c2          <= s_c2;
        idx_valid_q <= 1'b1;
        idx0_q      <= s_idx0;
        idx1_q      <= s_idx1;
        idx2_q      <= s_idx2;
        addr_q      <= flat_addr(s_idx0, s_idx1, s_idx2);
        idx_last_q  <= s_last;
      end else if (finish_run) begin
        idx_valid_q <= 1'b0;
        idx_last_q  <= 1'b0;
      end
    end
  end

  assign bus.idx_valid = idx_valid_q;
  assign bus.idx0      = idx0_q;
  assign bus.idx1      = idx1_q;
  assign bus.idx2      = idx2_q;
  assign bus.addr      = addr_q;
  assign bus.idx_last  = idx_last_q;

endmodule

// File: tb/tb_nd_slice_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nd_slice_scan_sequencer
//
// Drives commands into nd_slice_scan_sequencer and compares every emitted
// element against a list built from nested loops over the slice in the
// requested nesting order.
// ---------------------------------------------------------------------------
module tb_nd_slice_scan_sequencer;

  localparam int D0 = 6;
  localparam int D1 = 4;
  localparam int D2 = 3;
  localparam int W0 = $clog2(D0);
  localparam int W1 = $clog2(D1);
  localparam int W2 = $clog2(D2);
  localparam int AW = $clog2(D0 * D1 * D2);

  typedef struct packed {
    logic [W0-1:0] i0;
    logic [W1-1:0] i1;
    logic [W2-1:0] i2;
    logic [AW-1:0] a;
    logic          last;
  } elem_t;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  elem_t exp_q[$];

  nd_slice_scan_sequencer_if #(.D0(D0), .D1(D1), .D2(D2)) bus ();

  nd_slice_scan_sequencer #(.D0(D0), .D1(D1), .D2(D2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every element of the slice, listed by walking the three dimensions as
  // plain nested loops (outer loop first) in the requested order.
  function automatic void build_model(input int order, input int base,
                                      input int len, input int rot1,
                                      input int rot2);
    int    nest[3];
    int    sz[3];
    int    cnt[3];
    int    i0, i1, i2;
    elem_t e;
    exp_q.delete();
    case (order)
      1:       nest = '{0, 2, 1};
      2:       nest = '{1, 0, 2};
      3:       nest = '{1, 2, 0};
      4:       nest = '{2, 0, 1};
      5:       nest = '{2, 1, 0};
      default: nest = '{0, 1, 2};
    endcase
    sz = '{len, D1, D2};
    for (int a = 0; a < sz[nest[0]]; a++)
      for (int b = 0; b < sz[nest[1]]; b++)
        for (int c = 0; c < sz[nest[2]]; c++) begin
          cnt[nest[0]] = a;
          cnt[nest[1]] = b;
          cnt[nest[2]] = c;
          i0 = base + cnt[0];
          i1 = (cnt[1] + rot1) % D1;
          i2 = (cnt[2] + rot2) % D2;
          e.i0   = i0[W0-1:0];
          e.i1   = i1[W1-1:0];
          e.i2   = i2[W2-1:0];
          e.a    = AW'((i0 * D1 + i1) * D2 + i2);
          e.last = 1'b0;
          exp_q.push_back(e);
        end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Issues one command and follows the scan to its end. ready_pct sets the
  // consumer acceptance rate, stall_at (>0) holds idx_ready low for 5 cycles
  // after that many accepts, abort_at (>0) aborts on that accept.
  task automatic run_scan(input int order, input int base, input int len,
                          input int rot1, input int rot2, input int ready_pct,
                          input int stall_at, input int abort_at,
                          output int n_acc, output int first_addr,
                          output int last_addr, output int cycles);
    logic        legal;
    elem_t       got, snap;
    int          stall_left;
    bit          stall_done, prev_stalled, stalled_now, aborting;
    logic [W0:0] len_v;
    logic [4:0]  st;

    legal = (len != 0) && (base + len <= D0);
    if (legal) build_model(order, base, len, rot1, rot2);
    else exp_q.delete();
    n_acc = 0; first_addr = -1; last_addr = -1; cycles = 0;
    stall_left = 0; stall_done = 0; prev_stalled = 0;
    snap = '0;

    len_v = len[W0:0];
    bus.cmd_valid = 1'b1;
    bus.cmd_order = order[2:0];
    bus.cmd_base0 = base[W0-1:0];
    bus.cmd_len0  = len_v;
    bus.cmd_rot1  = rot1[W1-1:0];
    bus.cmd_rot2  = rot2[W2-1:0];
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_idle: got %b expected 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.cmd_order = 3'($urandom);

    if (!legal) begin
      st = {bus.idx_valid, bus.idx_last, bus.done, bus.busy, bus.cmd_ready};
      n_checks++;
      if (st !== 5'b00110) begin
        n_fail++;
        $display("FAIL illegal_done: {valid,last,done,busy,ready} got %b expected 00110", st);
      end
      tick();
      st = {bus.idx_valid, bus.idx_last, bus.done, bus.busy, bus.cmd_ready};
      n_checks++;
      if (st !== 5'b00001) begin
        n_fail++;
        $display("FAIL illegal_idle: {valid,last,done,busy,ready} got %b expected 00001", st);
      end
      return;
    end

    while (n_acc < exp_q.size() && cycles < 2000) begin
      cycles++;
      got = {bus.idx0, bus.idx1, bus.idx2, bus.addr, bus.idx_last};
      n_checks++;
      if ({bus.idx_valid, bus.done, bus.busy, bus.cmd_ready, got} !==
          {1'b1, 1'b0, 1'b1, 1'b0, exp_q[n_acc]}) begin
        n_fail++;
        $display("FAIL elem[%0d]: valid=%b done=%b busy=%b ready=%b elem=%h expected valid=1 done=0 busy=1 ready=0 elem=%h",
                 n_acc, bus.idx_valid, bus.done, bus.busy, bus.cmd_ready, got, exp_q[n_acc]);
      end
      if (prev_stalled) begin
        n_checks++;
        if (got !== snap) begin
          n_fail++;
          $display("FAIL stall_hold: elem got %h expected %h", got, snap);
        end
      end

      if (stall_at != 0 && n_acc == stall_at && !stall_done) begin
        stall_left = 5;
        stall_done = 1;
        snap       = got;
      end
      stalled_now = (stall_left > 0);
      if (stalled_now) begin
        bus.idx_ready = 1'b0;
        stall_left--;
      end else begin
        bus.idx_ready = ($urandom_range(99) < ready_pct);
      end
      aborting  = (abort_at != 0) && bus.idx_ready && (n_acc + 1 == abort_at);
      bus.abort = aborting;
      if (bus.idx_ready) begin
        if (n_acc == 0) first_addr = int'(got.a);
        last_addr = int'(got.a);
        n_acc++;
      end
      prev_stalled = stalled_now;
      tick();
      bus.abort = 1'b0;

      if (aborting) begin
        bus.idx_ready = 1'b0;
        st = {bus.idx_valid, bus.idx_last, bus.done, bus.busy, bus.cmd_ready};
        n_checks++;
        if (st !== 5'b00001) begin
          n_fail++;
          $display("FAIL abort_idle: {valid,last,done,busy,ready} got %b expected 00001", st);
        end
        return;
      end
    end
    bus.idx_ready = 1'b0;

    n_checks++;
    if (n_acc != exp_q.size()) begin
      n_fail++;
      $display("FAIL scan_timeout: accepted %0d elements expected %0d", n_acc, exp_q.size());
    end
    st = {bus.idx_valid, bus.idx_last, bus.done, bus.busy, bus.cmd_ready};
    n_checks++;
    if (st !== 5'b00110) begin
      n_fail++;
      $display("FAIL done_pulse: {valid,last,done,busy,ready} got %b expected 00110", st);
    end
    tick();
    st = {bus.idx_valid, bus.idx_last, bus.done, bus.busy, bus.cmd_ready};
    n_checks++;
    if (st !== 5'b00001) begin
      n_fail++;
      $display("FAIL back_idle: {valid,last,done,busy,ready} got %b expected 00001", st);
    end
  endtask

  task automatic test_reset();
    logic [20:0] st;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    st = {bus.idx_valid, bus.idx0, bus.idx1, bus.idx2, bus.addr, bus.idx_last,
          bus.done, bus.busy, bus.cmd_ready};
    n_checks++;
    if (st !== 21'd1) begin
      n_fail++;
      $display("FAIL reset_state: outputs got %h expected 000001", st);
    end
  endtask

  task automatic test_order0_stream();
    int n, fa, la, cyc;
    run_scan(0, 2, 4, 1, 0, 100, 0, 0, n, fa, la, cyc);
    n_checks++;
    if (n != 48 || cyc != 48 || fa != 27 || la != 62) begin
      n_fail++;
      $display("FAIL order0_summary: count=%0d cycles=%0d first=%0d last=%0d expected 48 48 27 62",
               n, cyc, fa, la);
    end
  endtask

  task automatic test_order5();
    int n, fa, la, cyc;
    run_scan(5, 0, 2, 0, 2, 100, 0, 0, n, fa, la, cyc);
    n_checks++;
    if (n != 24 || fa != 2) begin
      n_fail++;
      $display("FAIL order5_summary: count=%0d first=%0d expected 24 2", n, fa);
    end
  endtask

  task automatic test_backpressure();
    int n, fa, la, cyc;
    run_scan(0, 1, 3, 3, 1, 100, 7, 0, n, fa, la, cyc);
    n_checks++;
    if (n != 36 || cyc != 41) begin
      n_fail++;
      $display("FAIL backpressure_summary: count=%0d cycles=%0d expected 36 41", n, cyc);
    end
  endtask

  task automatic test_illegal();
    int n, fa, la, cyc;
    run_scan(0, 5, 2, 0, 0, 100, 0, 0, n, fa, la, cyc);
    run_scan(3, 0, 0, 1, 1, 100, 0, 0, n, fa, la, cyc);
    run_scan(2, 0, 7, 2, 2, 100, 0, 0, n, fa, la, cyc);
    run_scan(1, 3, 15, 0, 0, 100, 0, 0, n, fa, la, cyc);
  endtask

  task automatic test_abort();
    int n, fa, la, cyc;
    run_scan(4, 0, 6, 2, 1, 100, 0, 10, n, fa, la, cyc);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL abort_count: accepted %0d expected 10", n);
    end
    // Next command on the very following cycle, offered with abort high
    // while idle; the abort must be ignored.
    bus.abort = 1'b1;
    run_scan(1, 4, 2, 1, 2, 100, 0, 0, n, fa, la, cyc);
    n_checks++;
    if (n != 24) begin
      n_fail++;
      $display("FAIL abort_followup: count=%0d expected 24", n);
    end
  endtask

  task automatic test_reset_midscan();
    logic [20:0] st;
    bus.cmd_valid = 1'b1;
    bus.cmd_order = 3'd0;
    bus.cmd_base0 = 3'd1;
    bus.cmd_len0  = 4'd3;
    bus.cmd_rot1  = 2'd2;
    bus.cmd_rot2  = 2'd1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.idx_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.idx_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.idx_valid !== 1'b1 || bus.addr === '0) begin
      n_fail++;
      $display("FAIL midscan_setup: valid=%b addr=%0d expected valid=1 addr!=0", bus.idx_valid, bus.addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st = {bus.idx_valid, bus.idx0, bus.idx1, bus.idx2, bus.addr, bus.idx_last,
          bus.done, bus.busy, bus.cmd_ready};
    n_checks++;
    if (st !== 21'd1) begin
      n_fail++;
      $display("FAIL midscan_reset: outputs got %h expected 000001", st);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.idx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midscan_quiet: done=%b valid=%b expected 0 0", bus.done, bus.idx_valid);
      end
    end
  endtask

  task automatic test_random();
    int n, fa, la, cyc;
    int order, base, len;
    for (int k = 0; k < 8; k++) begin
      order = $urandom_range(7);
      base  = $urandom_range(D0 - 1);
      len   = $urandom_range(D0 - base, 1);
      run_scan(order, base, len, $urandom_range(3), $urandom_range(3),
               $urandom_range(90, 40), (k % 3 == 0) ? 3 : 0, 0,
               n, fa, la, cyc);
      n_checks++;
      if (n != len * D1 * D2) begin
        n_fail++;
        $display("FAIL random_count[%0d]: count=%0d expected %0d", k, n, len * D1 * D2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, fa, la, cyc;
    run_scan(3, 5, 1, 1, 0, 100, 0, 0, n, fa, la, cyc);
    run_scan(0, 0, 0, 0, 0, 100, 0, 0, n, fa, la, cyc);
    run_scan(2, 0, 1, 0, 3, 70, 0, 0, n, fa, la, cyc);
    n_checks++;
    if (n != 12) begin
      n_fail++;
      $display("FAIL back_to_back_count: count=%0d expected 12", n);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_order = '0;
    bus.cmd_base0 = '0;
    bus.cmd_len0  = '0;
    bus.cmd_rot1  = '0;
    bus.cmd_rot2  = '0;
    bus.abort     = 1'b0;
    bus.idx_ready = 1'b0;

    test_reset();
    test_order0_stream();
    test_order5();
    test_backpressure();
    test_illegal();
    test_abort();
    test_reset_midscan();
    test_random();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nd_slice_scan_sequencer.md
Name: nd_slice_scan_sequencer

Overview:
- Address/index sequencer for an N-d array datapath of shape [D0][D1][D2], the packed form used by the nd-array index slicing logic.
- On each command it walks a slice of dimension 0 with a runtime-selected loop-nest order and per-dimension rotation offsets on dims 1 and 2.
- Emits one element index triple plus flat address per handshake.
- Sits between the array storage (register file or SRAM) and the consumer that builds permuted or rotated sub-arrays.

Parameters:
D0, 6, size of outermost dimension
D1, 4, size of middle dimension
D2, 3, size of innermost dimension
W0, $clog2(D0), index width for dim0 (derived)
W1, $clog2(D1), index width for dim1 (derived)
W2, $clog2(D2), index width for dim2 (derived)
AW, $clog2(D0*D1*D2), flat address width (derived)

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_order  in  3  loop-nest order, outer to inner: 0=0-1-2, 1=0-2-1, 2=1-0-2, 3=1-2-0, 4=2-0-1, 5=2-1-0; 6 and 7 behave as 0
cmd_base0  in  W0  first dim0 index of slice
cmd_len0  in  W0+1  number of dim0 indices in slice
cmd_rot1  in  W1  rotation offset on dim1
cmd_rot2  in  W2  rotation offset on dim2
abort  in  1  terminate current scan
idx_valid  out  1  index output valid
idx_ready  in  1  consumer accepts
idx0  out  W0  dim0 index
idx1  out  W1  dim1 index
idx2  out  W2  dim2 index
addr  out  AW  flat address
idx_last  out  1  marks the final element of the scan
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Single clock CLK. RESET is synchronous and active-high.
- Reset values:
  - state=IDLE, idx_valid=0, idx0/idx1/idx2/addr=0, idx_last=0, busy=0, done=0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- States are IDLE, RUN and DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid&cmd_ready. All cmd_* fields are latched on acceptance.
  - Legal command: cmd_len0!=0 and cmd_base0+cmd_len0<=D0. Legal -> RUN.
  - Illegal command -> DONE directly. No element is emitted.
- RUN:
  - Internal counters c0 in [0,len0), c1 in [0,D1), c2 in [0,D2) all start at 0.
  - idx0=base0+c0.
  - idx1=(c1+rot1) mod D1.
  - idx2=(c2+rot2) mod D2.
  - addr=(idx0*D1+idx1)*D2+idx2, computed at full width (no truncation before the final AW bits).
  - Outputs are registered. The first element appears with idx_valid=1 in the cycle after command acceptance (latency 1).
  - The element advances only on idx_valid&idx_ready, at most one element per cycle. Counters step innermost first per cmd_order and carry into the next-outer counter on wrap.
  - While idx_valid&!idx_ready, idx0/idx1/idx2/addr/idx_last hold stable.
  - idx_last=1 exactly when every counter is at its maximum.
  - When the last element is accepted: next cycle idx_valid=0, state=DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 during DONE.
- abort:
  - Sampled only in RUN. It wins over any simultaneous handshake: an element accepted in the abort cycle counts as delivered.
  - Next cycle: idx_valid=0, idx_last=0, state=IDLE, done stays 0.
  - abort in IDLE or DONE is ignored.
- RESET asserted mid-scan: next cycle all outputs return to reset values. No done pulse is produced.
- busy=1 in RUN and DONE.
- Element count for a legal command is len0*D1*D2. Every (idx0,idx1,idx2) in the slice is emitted exactly once.

Test Plan:
- Defaults, order=0, base0=2, len0=4, rot1=1, rot2=0, idx_ready tied 1 -> 48 elements on consecutive cycles. First element (2,1,0) addr 27, second (2,1,1) addr 28, fourth (2,2,0) addr 30, last (5,0,2) addr 62 with idx_last=1. done pulses exactly 1 cycle after the last accept. Command accepted at cycle t gives first idx_valid at t+1.
- order=5, base0=0, len0=2, rot1=0, rot2=2 -> first outputs (0,0,2) addr 2, (1,0,2) addr 14, (0,1,2) addr 5. Total 24 elements, all addresses unique.
- Backpressure: idx_ready low for 5 cycles mid-scan -> idx0/idx1/idx2/addr/idx_last unchanged across all 5 cycles. Scan resumes with the next element; no element is skipped or duplicated.
- Illegal commands base0=5, len0=2 and len0=0 -> idx_valid never rises. done=1 at cycle t+1, cmd_ready=1 again at t+2.
- abort asserted on the 10th accept cycle -> idx_valid=0 next cycle, done never pulses, busy=0. A new command is accepted on the following cycle.
- RESET for 1 cycle mid-scan while idx_valid=1 and idx_ready=0 -> next cycle idx_valid=0, addr=0, busy=0, cmd_ready=1.
